// File: rtl/mio_bus_responder_if.sv
// CPU memory-port bundle between the multicycle CPU (master) and the MIO responder (slave).
interface mio_bus_responder_if;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [31:0] Data_in;
    logic        MIO_ready;
    logic        bus_err;

    modport master (
        output CPU_MIO, mem_w, Addr_out, Data_out,
        input  Data_in, MIO_ready, bus_err
    );

    modport slave (
        input  CPU_MIO, mem_w, Addr_out, Data_out,
        output Data_in, MIO_ready, bus_err
    );
endinterface

// File: rtl/mio_bus_responder.sv
// Memory/IO responder: word RAM, GPIO register and cycle counter behind a fixed decode,
// acknowledged after a programmable number of wait states.
module mio_bus_responder #(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 1
) (
    input  logic                clk,
    input  logic                reset,
    mio_bus_responder_if.slave  bus,
    input  logic [31:0]         sw_in,
    output logic [31:0]         gpio_out
);

    localparam logic [3:0] RdWait = 4'(RD_WAIT);
    localparam logic [3:0] WrWait = 4'(WR_WAIT);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          region_q;
    logic [RAM_AW-1:0]   idx_q;
    logic                we_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [31:0]         gpio_q;
    logic [31:0]         count_q;
    logic                err_q;
    logic [31:0]         mem [2**RAM_AW];

    logic                live;
    logic [3:0]          c_region;
    logic [RAM_AW-1:0]   c_idx;
    logic                c_we;
    logic [31:0]         c_wdata;
    logic [3:0]          wait_sel;
    logic                commit;
    logic                is_ram, is_gpio, is_cnt, mapped;
    logic [31:0]         rd_mux;
    logic                unused_addr;

    assign unused_addr = ^{bus.Addr_out[27:RAM_AW+2], bus.Addr_out[1:0]};

    // With zero wait states the commit happens on the sampling edge, so decode the live bus.
    assign live     = (state_q == StIdle);
    assign c_region = live ? bus.Addr_out[31:28]       : region_q;
    assign c_idx    = live ? bus.Addr_out[RAM_AW+1:2]  : idx_q;
    assign c_we     = live ? bus.mem_w                 : we_q;
    assign c_wdata  = live ? bus.Data_out              : wdata_q;
    assign wait_sel = bus.mem_w ? WrWait : RdWait;

    assign is_ram  = (c_region == 4'h0);
    assign is_gpio = (c_region == 4'hE);
    assign is_cnt  = (c_region == 4'hF);
    assign mapped  = is_ram | is_gpio | is_cnt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.CPU_MIO) begin
                    if (wait_sel == 4'd0) begin
                        state_d = StAck;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = wait_sel - 4'd1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAck;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_mux = 32'h0;
        if (is_ram) begin
            rd_mux = mem[c_idx];
        end else if (is_gpio) begin
            rd_mux = sw_in;
        end else if (is_cnt) begin
            rd_mux = count_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            region_q <= 4'd0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            gpio_q   <= 32'h0;
            count_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= commit & ~mapped;
            if (live && bus.CPU_MIO) begin
                region_q <= bus.Addr_out[31:28];
                idx_q    <= bus.Addr_out[RAM_AW+1:2];
                we_q     <= bus.mem_w;
                wdata_q  <= bus.Data_out;
            end
            if (commit && !c_we) begin
                rdata_q <= rd_mux;
            end
            if (commit && c_we && is_gpio) begin
                gpio_q <= c_wdata;
            end
            // Clear beats the free-running increment on the same edge.
            if (commit && c_we && is_cnt) begin
                count_q <= 32'h0;
            end else begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // RAM is never reset; the reset gate keeps a write from landing while reset is held.
    always_ff @(posedge clk) begin
        if (reset && commit && c_we && is_ram) begin
            mem[c_idx] <= c_wdata;
        end
    end

    assign bus.MIO_ready = (state_q == StAck);
    assign bus.bus_err   = err_q;
    assign bus.Data_in   = rdata_q;
    assign gpio_out      = gpio_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench for mio_bus_responder: the driver queues expected acknowledges,
// a negedge monitor pops and checks them as MIO_ready appears.
module tb_mio_bus_responder;

    localparam int unsigned RdW = 2;
    localparam int unsigned WrW = 1;

    typedef struct {
        int          edge_no;
        logic [31:0] data;
        logic        err;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] sw_in = 32'h0;
    logic [31:0] gpio_out;

    mio_bus_responder_if bus ();

    mio_bus_responder #(
        .RAM_AW (10),
        .RD_WAIT(RdW),
        .WR_WAIT(WrW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .sw_in   (sw_in),
        .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = 32'h0;
    int          zero_edge = 0;
    int          n_issued = 0;
    logic        prev_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One transaction; expected Data_in for writes is the last read value (writes leave it).
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rexp, input logic err, input logic is_cnt);
        int unsigned w;
        exp_t e;
        w = we ? WrW : RdW;
        @(negedge clk);
        bus.CPU_MIO  = 1'b1;
        bus.mem_w    = we;
        bus.Addr_out = addr;
        bus.Data_out = wdata;
        e.edge_no = edge_cnt + 1 + int'(w);
        if (!we) last_rd = is_cnt ? 32'(e.edge_no - 1 - zero_edge) : rexp;
        if (we && addr[31:28] == 4'hF) zero_edge = e.edge_no;
        e.data = last_rd;
        e.err  = err;
        e.id   = n_issued++;
        sb.push_back(e);
        @(negedge clk);
        bus.CPU_MIO = 1'b0;
        repeat (w + 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.MIO_ready) begin
                check("ack_not_consecutive", {31'h0, prev_rdy}, 32'h0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got MIO_ready=1 expected 0 (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("ack%0d_edge", e.id), edge_cnt, e.edge_no);
                    check($sformatf("ack%0d_data", e.id), bus.Data_in, e.data);
                    check($sformatf("ack%0d_err", e.id), {31'h0, bus.bus_err}, {31'h0, e.err});
                end
            end else if (bus.bus_err) begin
                checks++;
                errors++;
                $display("FAIL err_without_ack: got bus_err=1 expected 0 (t=%0t)", $time);
            end
        end
        prev_rdy = bus.MIO_ready;
    end

    initial begin
        int k;
        bus.CPU_MIO  = 1'b0;
        bus.mem_w    = 1'b0;
        bus.Addr_out = 32'h0;
        bus.Data_out = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_data_in", bus.Data_in, 32'h0);
        check("rst_ready", {31'h0, bus.MIO_ready}, 32'h0);
        check("rst_err", {31'h0, bus.bus_err}, 32'h0);
        check("rst_gpio", gpio_out, 32'h0);
        check("rst_count", dut.count_q, 32'h0);
        reset = 1'b1;

        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        issue(1'b1, 32'h0000_0000, 32'hA0A0_A0A0, 32'h0, 1'b0, 1'b0);
        issue(1'b1, 32'h0000_0004, 32'hB0B0_B0B0, 32'h0, 1'b0, 1'b0);
        issue(1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0, 1'b0, 1'b0);

        issue(1'b1, 32'hE000_0000, 32'h0000_00A5, 32'h0, 1'b0, 1'b0);
        check("gpio_written", gpio_out, 32'h0000_00A5);
        sw_in = 32'h1234_5678;
        issue(1'b0, 32'hE000_0004, 32'h0, 32'h1234_5678, 1'b0, 1'b0);

        issue(1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        issue(1'b0, 32'hF000_0000, 32'h0, 32'h0, 1'b0, 1'b1);

        @(negedge clk);
        force dut.count_q = 32'hFFFF_FFFF;
        zero_edge = edge_cnt + 1;
        #1 release dut.count_q;
        @(negedge clk);
        check("count_wrap", dut.count_q, 32'h0);
        zero_edge = edge_cnt;
        issue(1'b0, 32'hF000_0000, 32'h0, 32'h0, 1'b0, 1'b1);

        issue(1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h8000_0000, 32'h5555_5555, 32'h0, 1'b1, 1'b0);
        check("gpio_after_unmapped", gpio_out, 32'h0000_00A5);
        issue(0, 32'h0000_0000, 32'h0, 32'hA0A0_A0A0, 1'b0, 1'b0);

        // Two reads back to back with CPU_MIO held high throughout.
        @(negedge clk);
        bus.CPU_MIO  = 1'b1;
        bus.mem_w    = 1'b0;
        bus.Addr_out = 32'h0000_0000;
        k = edge_cnt + 1;
        sb.push_back('{edge_no: k + 2, data: 32'hA0A0_A0A0, err: 1'b0, id: n_issued});
        sb.push_back('{edge_no: k + 6, data: 32'hB0B0_B0B0, err: 1'b0, id: n_issued + 1});
        n_issued += 2;
        last_rd = 32'hB0B0_B0B0;
        repeat (3) @(negedge clk);
        bus.Addr_out = 32'h0000_0004;
        repeat (2) @(negedge clk);
        bus.CPU_MIO = 1'b0;
        repeat (3) @(negedge clk);

        // Reset lands while a write to 0x20 is waiting.
        @(negedge clk);
        bus.CPU_MIO  = 1'b1;
        bus.mem_w    = 1'b1;
        bus.Addr_out = 32'h0000_0020;
        bus.Data_out = 32'h2222_2222;
        @(negedge clk);
        bus.CPU_MIO = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_gpio", gpio_out, 32'h0);
        check("midrst_count", dut.count_q, 32'h0);
        @(negedge clk);
        check("midrst_ready", {31'h0, bus.MIO_ready}, 32'h0);
        check("midrst_data_in", bus.Data_in, 32'h0);
        reset = 1'b1;
        last_rd = 32'h0;
        issue(1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO responder for the multicycle CPU bus: answers each CPU_MIO transaction with a programmable wait-state delay, a one-cycle MIO_ready acknowledge and registered read data. It sits on the CPU's memory port, with port names matching the CPU side, and contains the word RAM, a GPIO register and a free-running cycle counter behind a fixed address decode.

## Interface
- RAM_AW, 10: RAM word-address width (2^RAM_AW 32-bit words).
- RD_WAIT, 2: wait cycles inserted for reads (0..15).
- WR_WAIT, 1: wait cycles inserted for writes (0..15).
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- CPU_MIO  input  1  transaction request; Addr_out, mem_w and Data_out are stable while it is high.
- mem_w  input  1  1 = write, 0 = read.
- Addr_out  input  32  byte address; bits [1:0] are ignored.
- Data_out  input  32  write data.
- sw_in  input  32  GPIO input pins.
- Data_in  output  32  read data to the CPU (registered).
- MIO_ready  output  1  one-cycle transaction acknowledge.
- gpio_out  output  32  GPIO output register.
- bus_err  output  1  one-cycle pulse, concurrent with MIO_ready, for an unmapped address.

## Operation
- Decode on Addr_out[31:28]:
  - 0x0: RAM, word index Addr_out[RAM_AW+1:2].
  - 0xE: GPIO. Write loads gpio_out; read returns sw_in.
  - 0xF: counter. Read returns the count; a write clears it (data ignored).
  - Any other value: unmapped. Read returns 0; write has no effect; bus_err pulses.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: CPU_MIO=1 latches the address, mem_w and data. Next state is ACK if the applicable wait count W is 0; otherwise WAIT with cnt = W-1.
  - WAIT: if cnt==0, go to ACK; else decrement cnt. CPU_MIO is ignored in this state.
  - ACK: MIO_ready=1 for exactly one cycle, then unconditionally return to IDLE.
- Back-to-back transactions: if CPU_MIO is still high when the FSM returns to IDLE, that is a new transaction.
- Commit point is the edge entering ACK. At that edge:
  - writes update RAM, gpio_out or the counter;
  - reads load Data_in.
- Data_in holds its value until the next read commit. Writes do not change Data_in.
- Counter: 32-bit, increments every cycle and wraps 0xFFFFFFFF -> 0. A clear and an increment on the same edge: clear wins, so the counter reads 0 on the next cycle. A read returns the value held before that edge's increment.
- GPIO read samples sw_in at the commit edge; sw_in is not synchronised.
- Reset (asynchronous, any state):
  - state IDLE; MIO_ready=0, bus_err=0, Data_in=0, gpio_out=0, counter=0.
  - An in-flight write is dropped.
  - RAM contents are not reset.

## Timing
- Request sampled in IDLE at edge k: MIO_ready is high in the cycle after edge k+W, i.e. latency W+1 cycles.
  - RD_WAIT=2: read acknowledge 3 cycles after the sampling edge.
  - W=0: acknowledge 1 cycle after the sampling edge.
- MIO_ready is never high in two consecutive cycles.
- Minimum spacing between acknowledges is W+2 cycles.
- Read data is valid on Data_in in the same cycle MIO_ready=1 and stays valid afterwards.
- Inputs changing during WAIT have no effect, since the request is latched at sampling.
- Reset deasserted mid-cycle: the first request can be sampled at the first rising edge with reset=1.

## Test plan
- Reset, then write 0xDEADBEEF to 0x00000010 (WR_WAIT=1) -> MIO_ready high exactly 2 cycles after the sampling edge, for 1 cycle. Read 0x00000010 (RD_WAIT=2) -> MIO_ready 3 cycles after sampling with Data_in=0xDEADBEEF.
- Write 0x000000A5 to 0xE0000000 -> gpio_out=0x000000A5 from the ACK cycle onward. With sw_in=0x12345678, read 0xE0000004 -> Data_in=0x12345678.
- Counter: write 0xF0000000 to clear, then read after 10 idle cycles -> Data_in equals the cycles elapsed from the clear edge to the read commit edge (bench computes it exactly). Counter forced to 0xFFFFFFFF -> wraps to 0.
- Read 0x80000000 -> Data_in=0, bus_err and MIO_ready both high for one cycle. Write 0x80000000 -> no RAM, GPIO or counter change.
- Hold CPU_MIO high across two reads of 0x0 and 0x4 -> two acknowledges W+2 cycles apart, each carrying the correct data.
- Assert reset during WAIT of a write to 0x00000020 -> MIO_ready stays 0, gpio_out=0, counter=0, and a later read of 0x00000020 returns its old contents.
